touch_cmd_tx: RTL and testbench
===============================

// Module: touch_cmd_tx
// PURPOSE
//  Hardware command transmitter for the touchscreen controller UART link: the host-to-panel direction of the link whose rxd side feeds the Nios.
//  Accepts one command (opcode + 0..4 payload bytes) per valid/ready handshake.
//  Emits it as a framed 8N1 serial packet on txd: 0x55, N (= len+1), opcode, payload bytes.
//  Sits between Nios/board-init logic and the touchscreen txd GPIO pin.
// PARAMETERS
//  CLK_HZ       50_000_000  input clock frequency
//  BAUD         9600        serial bit rate; DIV = CLK_HZ/BAUD, truncated (5208 at defaults)
//  MAX_PAYLOAD  4           maximum payload bytes per command
// PORTS
//  clk        in   1   single clock, all logic on rising edge
//  reset      in   1   asynchronous, active-high reset
//  cmd_valid  in   1   command present on cmd_code/cmd_len/cmd_data
//  cmd_ready  out  1   block can accept a command this cycle
//  cmd_code   in   8   command opcode
//  cmd_len    in   3   payload byte count, legal 0..MAX_PAYLOAD
//  cmd_data   in   32  payload; byte k = cmd_data[8k+7:8k], byte 0 sent first
//  txd        out  1   serial output, idle high
//  busy       out  1   frame in progress (INIT excluded)
//  done       out  1   one-cycle pulse: frame's final stop bit completed
//  err        out  1   one-cycle pulse: illegal cmd_len rejected
// BEHAVIOUR
//  Reset values: txd=1, cmd_ready=0, busy=0, done=0, err=0; state=INIT, counters cleared.
//  All outputs are registered.
//  INIT: txd held high for 10*DIV cycles (receiver resync), then IDLE.
//  IDLE: cmd_ready=1. Accept on the edge where cmd_valid&cmd_ready; capture code/len/data; cmd_ready=0 the next cycle.
//  Illegal length (cmd_len>MAX_PAYLOAD):
//   - err=1 for one cycle; no frame sent.
//   - Stay IDLE; cmd_ready stays 1; done is not pulsed.
//  Legal length:
//   - busy=1 and txd falls (start bit of 0x55) on the edge after acceptance.
//  SEND: byte sequence 0x55, len+1, code, data[0..len-1]; byte count = 3+len.
//  Per byte:
//   - start bit 0, then bits 0..7 LSB first, then stop bit 1.
//   - Each bit lasts exactly DIV cycles.
//   - No idle gap between bytes.
//  Frame duration: exactly (3+len)*10*DIV cycles from the first txd fall to the end of the last stop bit.
//  End of frame: on the edge ending the last stop bit, done=1 (one cycle), busy=0, cmd_ready=1, state IDLE.
//   - A new command may be accepted in that same cycle.
//   - Back-to-back frames therefore have no extra gap.
//  cmd_valid while busy: ignored, not stored; the upstream holds it until ready.
//  Inputs are sampled only at acceptance; changes mid-frame have no effect.
//  Reset mid-frame: txd returns high immediately (async); the frame is abandoned; state is INIT.
//  Baud counter: counts 0..DIV-1 and wraps; sized $clog2(DIV).
//  Bit index: 0..9. Byte index: 0..2+MAX_PAYLOAD.
// STRUCTURE
//  touch_pkg: TOUCH_SYNC=8'h55.
//   - Opcodes TOUCH_ENABLE=8'h12, TOUCH_DISABLE=8'h13, TOUCH_CALIBRATE=8'h14.
//   - State enum {INIT, IDLE, SEND}.
//  Sub-module uart_tx_byte:
//   - Byte serializer with its own baud counter.
//   - Handshake: load/byte_in/txd/byte_done.
//  touch_cmd_tx: frame FSM, byte sequencing, length check.
// TESTING (sim with CLK_HZ=1000, BAUD=100 -> DIV=10)
//  1 Reset release: txd=1 and cmd_ready=0 for exactly 100 cycles -> cmd_ready=1 on cycle 101.
//  2 cmd_code=8'h12, cmd_len=0 -> bytes 55,01,12 decoded by a bench UART model.
//    - 300 cycles start-to-stop; done pulses once; busy is high throughout.
//  3 cmd_code=8'h14, len=4, data=32'hDDCCBBAA -> bytes 55,05,14,AA,BB,CC,DD.
//    - 700 cycles; each bit 10 cycles wide (checked on every txd edge).
//  4 cmd_len=5 -> err one-cycle pulse, txd stays 1, cmd_ready stays 1, no done.
//  5 Two commands, valid held continuously -> second start bit immediately follows first frame's last stop bit.
//    - Second accepted on the done cycle.
//  6 Assert reset at cycle 150 of a len=2 frame -> txd=1 the same cycle.
//    - INIT repeats (100 cycles), then a fresh command is sent intact.

Source files
------------

// File: rtl/touch_pkg.sv
// touch_pkg
//   Shared constants and types for the touchscreen command transmitter:
//   frame sync byte, touchscreen opcodes, frame FSM state encoding and a
//   helper that returns the n-th byte of a command frame.
package touch_pkg;

    localparam logic [7:0] TOUCH_SYNC      = 8'h55;
    localparam logic [7:0] TOUCH_ENABLE    = 8'h12;
    localparam logic [7:0] TOUCH_DISABLE   = 8'h13;
    localparam logic [7:0] TOUCH_CALIBRATE = 8'h14;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SEND = 2'd2
    } touch_state_e;

    // Frame layout: SYNC, len+1, opcode, payload[0..len-1].
    // Payload byte k sits at frame index k+3; idx[1:0]+1 maps 3..6 onto 0..3.
    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic [2:0]  len,
        input logic [7:0]  code,
        input logic [31:0] data
    );
        logic [4:0] sh;
        sh = {idx[1:0] + 2'd1, 3'b000};
        case (idx)
            3'd0:    frame_byte = TOUCH_SYNC;
            3'd1:    frame_byte = {5'd0, len} + 8'd1;
            3'd2:    frame_byte = code;
            default: frame_byte = data[sh +: 8];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   8N1 byte serializer with its own baud counter. A load starts a byte
//   immediately (start bit driven on the load edge), even if the previous
//   byte is in its last stop-bit cycle, so consecutive bytes abut with no
//   idle gap.
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (txd forced high)
//   i_load       start serializing i_byte_in on this edge
//   i_byte_in    byte to send, LSB first
//   o_txd        registered serial output, idle high
//   o_byte_done  high during the final cycle of the stop bit
//   o_stop_near  high one cycle before o_byte_done (lets a parent register
//                its own pulse so it lines up with o_byte_done)
module uart_tx_byte #(
    parameter int unsigned DIV = 5208   // must be >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_byte_in,
    output logic       o_txd,
    output logic       o_byte_done,
    output logic       o_stop_near
);

    localparam int unsigned      CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(DIV - 2);

    logic [CNT_W-1:0] r_baud_cnt;
    logic [3:0]       r_bit_idx;    // 0 start, 1..8 data, 9 stop
    logic [7:0]       r_shift;
    logic             r_active;
    logic             r_txd;
    logic             r_byte_done;

    assign o_stop_near = r_active && (r_bit_idx == 4'd9) && (r_baud_cnt == CNT_NEAR);
    assign o_txd       = r_txd;
    assign o_byte_done = r_byte_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_active    <= 1'b0;
            r_txd       <= 1'b1;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= o_stop_near & ~i_load;
            if (i_load) begin
                r_active   <= 1'b1;
                r_txd      <= 1'b0;
                r_shift    <= i_byte_in;
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
            end else if (r_active) begin
                if (r_baud_cnt == CNT_LAST) begin
                    r_baud_cnt <= '0;
                    if (r_bit_idx == 4'd9) begin
                        r_active  <= 1'b0;
                        r_bit_idx <= '0;
                    end else begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == 4'd8) begin
                            r_txd <= 1'b1;
                        end else begin
                            r_txd   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/touch_cmd_tx.sv
// touch_cmd_tx
//   Host-to-panel command transmitter for the touchscreen UART link.
//   Accepts one command per valid/ready handshake and sends it as
//   0x55, len+1, opcode, payload[0..len-1] in 8N1 at BAUD.
//
//   state | meaning
//   INIT  | txd held high 10 bit times so the panel receiver resyncs
//   IDLE  | cmd_ready high, waiting for a command
//   SEND  | frame bytes being serialized back to back
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   cmd_valid / cmd_ready  command handshake
//   cmd_code, cmd_len,     opcode, payload length (0..MAX_PAYLOAD),
//   cmd_data               payload (byte 0 in [7:0], sent first)
//   txd                    serial output, idle high
//   busy                   frame in progress
//   done                   one-cycle pulse in the frame's final stop-bit cycle
//   err                    one-cycle pulse when a command with bad length is refused
module touch_cmd_tx
    import touch_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned MAX_PAYLOAD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        txd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned       DIV         = CLK_HZ / BAUD;
    localparam int unsigned       INIT_CYCLES = 10 * DIV;
    localparam int unsigned       INIT_W      = $clog2(INIT_CYCLES);
    localparam logic [INIT_W-1:0] INIT_LAST   = INIT_W'(INIT_CYCLES - 1);
    localparam logic [2:0]        MAX_LEN     = 3'(MAX_PAYLOAD);

    touch_state_e      r_state, w_nxt_state;
    logic [INIT_W-1:0] r_init_cnt, w_nxt_init_cnt;
    logic [2:0]        r_byte_idx, w_nxt_byte_idx;
    logic [7:0]        r_code;
    logic [2:0]        r_len;
    logic [31:0]       r_data;
    logic              r_cmd_ready, w_nxt_ready;
    logic              r_busy, w_nxt_busy;
    logic              r_done, w_nxt_done;
    logic              r_err, w_nxt_err;
    logic              w_capture;
    logic              w_load;
    logic [7:0]        w_byte_in;
    logic              w_txd;
    logic              w_byte_done;
    logic              w_stop_near;
    logic [2:0]        w_last_idx;

    assign w_last_idx = r_len + 3'd2;

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_byte_in   (w_byte_in),
        .o_txd       (w_txd),
        .o_byte_done (w_byte_done),
        .o_stop_near (w_stop_near)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_byte_idx  <= '0;
            r_code      <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_init_cnt  <= w_nxt_init_cnt;
            r_byte_idx  <= w_nxt_byte_idx;
            r_cmd_ready <= w_nxt_ready;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_err       <= w_nxt_err;
            if (w_capture) begin
                r_code <= cmd_code;
                r_len  <= cmd_len;
                r_data <= cmd_data;
            end
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_init_cnt = r_init_cnt;
        w_nxt_byte_idx = r_byte_idx;
        w_nxt_ready    = r_cmd_ready;
        w_nxt_busy     = r_busy;
        w_nxt_done     = 1'b0;
        w_nxt_err      = 1'b0;
        w_capture      = 1'b0;
        w_load         = 1'b0;
        w_byte_in      = TOUCH_SYNC;
        case (r_state)
            INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_nxt_state    = IDLE;
                    w_nxt_ready    = 1'b1;
                    w_nxt_init_cnt = '0;
                end else begin
                    w_nxt_init_cnt = r_init_cnt + INIT_W'(1);
                end
            end
            IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    if (cmd_len > MAX_LEN) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        // Start bit of the sync byte goes out on the accept edge.
                        w_capture      = 1'b1;
                        w_load         = 1'b1;
                        w_byte_in      = TOUCH_SYNC;
                        w_nxt_state    = SEND;
                        w_nxt_ready    = 1'b0;
                        w_nxt_busy     = 1'b1;
                        w_nxt_byte_idx = '0;
                    end
                end
            end
            SEND: begin
                if (w_byte_done && (r_byte_idx != w_last_idx)) begin
                    w_load         = 1'b1;
                    w_byte_in      = frame_byte(r_byte_idx + 3'd1, r_len, r_code, r_data);
                    w_nxt_byte_idx = r_byte_idx + 3'd1;
                end
                // Returning to IDLE one cycle early puts done/ready in the last
                // stop-bit cycle, so a command accepted then starts with no gap.
                if (w_stop_near && (r_byte_idx == w_last_idx)) begin
                    w_nxt_state = IDLE;
                    w_nxt_done  = 1'b1;
                    w_nxt_busy  = 1'b0;
                    w_nxt_ready = 1'b1;
                end
            end
            default: begin
                w_nxt_state = INIT;
            end
        endcase
    end

    assign txd       = w_txd;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_touch_cmd_tx.sv
module tb_touch_cmd_tx;
    import touch_pkg::*;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_code = '0;
    logic [2:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, txd, busy, done, err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_bytes  = 0;
    logic [7:0]  sb_q[$];

    always #5 clk = ~clk;

    touch_cmd_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_PAYLOAD(4)) dut (
        .clk       (clk),
        .reset     (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .txd       (txd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] code, input logic [2:0] len, input logic [31:0] data);
        sb_q.push_back(8'h55);
        sb_q.push_back({5'd0, len} + 8'd1);
        sb_q.push_back(code);
        for (int k = 0; k < int'(len); k++) sb_q.push_back(data[8*k +: 8]);
    endtask

    // Bench UART receiver: every sample of each bit window must hold one value.
    initial begin : uart_mon
        logic [7:0] val;
        logic [7:0] expb;
        logic       cur;
        logic       width_ok;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                val = '0; width_ok = 1'b1; aborted = 1'b0; cur = 1'b0;
                for (int s = 1; s < 10*DIV; s++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (s % DIV == 0) begin
                        cur = txd;
                        if (s/DIV >= 1 && s/DIV <= 8) val[s/DIV-1] = txd;
                    end else if (txd !== cur) begin
                        width_ok = 1'b0;
                    end
                    if (s/DIV == 9 && txd !== 1'b1) width_ok = 1'b0;
                end
                if (!aborted) begin
                    n_bytes++;
                    check_eq("sb_byte_expected", (sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        expb = sb_q.pop_front();
                        check_eq("uart_byte", val, expb);
                    end
                    check_eq("bit_timing", width_ok, 1);
                end
            end
        end
    end

    task automatic wait_init(output int n_low, output int txd_low);
        n_low = 0; txd_low = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) break;
            n_low++;
            if (txd !== 1'b1) txd_low++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic drive_cmd(input logic [7:0] code, input logic [2:0] len, input logic [31:0] data);
        int w;
        cmd_code = code; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        if (len <= 3'd4) push_frame(code, len, data);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
    endtask

    // Counts samples from the first start bit through the done sample.
    task automatic measure_frame(output int cyc, output int busy_low, output int done_seen);
        cyc = 0; busy_low = 0; done_seen = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc++;
            if (done === 1'b1) begin
                done_seen = 1;
                break;
            end
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
        end
    endtask

    task automatic quiet_window(output int n_done, output int n_txd_low);
        n_done = 0; n_txd_low = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (txd !== 1'b1) n_txd_low++;
        end
    endtask

    initial begin
        int n_low, t_low, cyc, bl, ds, nd;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_txd", txd, 1);
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);

        // 1: INIT duration
        @(posedge clk); #1 rst = 1'b0;
        wait_init(n_low, t_low);
        check_eq("init_ready_low_cycles", n_low, 100);
        check_eq("init_txd_low", t_low, 0);

        // 2: enable, no payload
        drive_cmd(TOUCH_ENABLE, 3'd0, 32'h0);
        cmd_valid = 1'b0;
        check_eq("t2_start_txd", txd, 0);
        check_eq("t2_start_busy", busy, 1);
        check_eq("t2_ready_low", cmd_ready, 0);
        measure_frame(cyc, bl, ds);
        check_eq("t2_frame_cycles", cyc, 300);
        check_eq("t2_busy_gaps", bl, 0);
        check_eq("t2_done_seen", ds, 1);
        check_eq("t2_done_busy", busy, 0);
        check_eq("t2_done_ready", cmd_ready, 1);
        quiet_window(nd, t_low);
        check_eq("t2_extra_done", nd, 0);
        check_eq("t2_sb_empty", sb_q.size(), 0);

        // 3: calibrate, full payload; inputs scrambled mid-frame
        drive_cmd(TOUCH_CALIBRATE, 3'd4, 32'hDDCCBBAA);
        cmd_valid = 1'b0; cmd_code = 8'hFF; cmd_len = 3'd1; cmd_data = 32'h0;
        measure_frame(cyc, bl, ds);
        check_eq("t3_frame_cycles", cyc, 700);
        check_eq("t3_busy_gaps", bl, 0);
        check_eq("t3_done_seen", ds, 1);
        quiet_window(nd, t_low);
        check_eq("t3_sb_empty", sb_q.size(), 0);

        // 4: illegal length
        cmd_code = TOUCH_DISABLE; cmd_len = 3'd5; cmd_valid = 1'b1;
        @(negedge clk);
        check_eq("t4_err_pulse", err, 1);
        check_eq("t4_ready_kept", cmd_ready, 1);
        check_eq("t4_busy", busy, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_err_cleared", err, 0);
        quiet_window(nd, t_low);
        check_eq("t4_no_done", nd, 0);
        check_eq("t4_txd_idle", t_low, 0);
        check_eq("t4_ready_idle", cmd_ready, 1);

        // 5: back-to-back with valid held
        drive_cmd(TOUCH_ENABLE, 3'd1, 32'h000000A5);
        cmd_code = TOUCH_DISABLE; cmd_len = 3'd3; cmd_data = 32'h00332211;
        push_frame(TOUCH_DISABLE, 3'd3, 32'h00332211);
        measure_frame(cyc, bl, ds);
        check_eq("t5a_frame_cycles", cyc, 400);
        check_eq("t5a_done_seen", ds, 1);
        check_eq("t5a_done_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("t5_no_gap_txd", txd, 0);
        check_eq("t5b_busy", busy, 1);
        measure_frame(cyc, bl, ds);
        check_eq("t5b_frame_cycles", cyc, 600);
        check_eq("t5b_done_seen", ds, 1);
        quiet_window(nd, t_low);
        check_eq("t5_sb_empty", sb_q.size(), 0);

        // 6: reset mid-frame, then recover
        drive_cmd(TOUCH_CALIBRATE, 3'd2, 32'h0000BEEF);
        cmd_valid = 1'b0;
        repeat (149) @(negedge clk);
        check_eq("t6_pre_reset_txd", txd, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_txd", txd, 1);
        check_eq("t6_async_busy", busy, 0);
        repeat (2) @(negedge clk);
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        wait_init(n_low, t_low);
        check_eq("t6_init_ready_low_cycles", n_low, 100);
        check_eq("t6_init_txd_low", t_low, 0);
        drive_cmd(TOUCH_ENABLE, 3'd2, 32'h00007788);
        cmd_valid = 1'b0;
        measure_frame(cyc, bl, ds);
        check_eq("t6_frame_cycles", cyc, 500);
        check_eq("t6_done_seen", ds, 1);
        quiet_window(nd, t_low);
        check_eq("t6_sb_empty", sb_q.size(), 0);
        check_eq("total_bytes", n_bytes, 26);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
